// File: rtl/inst_decode_if.sv
// Signal bundle between the IF/ID, write-back and EX sides and the decode stage.
// The master modport is the decode stage itself; the slave is the surrounding pipeline.
interface inst_decode_if;
  logic [31:0] if_id_instr;
  logic [9:0]  if_id_NPC;
  logic        PCSrc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_stall;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [9:0]  id_ex_NPC;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_dest;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_branch;
  logic        id_ex_jump;

  modport master (
    input  if_id_instr, if_id_NPC, PCSrc, wb_we, wb_addr, wb_data,
    output id_stall, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_NPC,
           id_ex_rs, id_ex_rt, id_ex_dest, id_ex_alu_op, id_ex_reg_write,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch,
           id_ex_jump
  );

  modport slave (
    output if_id_instr, if_id_NPC, PCSrc, wb_we, wb_addr, wb_data,
    input  id_stall, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_NPC,
           id_ex_rs, id_ex_rt, id_ex_dest, id_ex_alu_op, id_ex_reg_write,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch,
           id_ex_jump
  );
endinterface

// File: rtl/inst_decode.sv
// KGP_RISC instruction-decode stage: register file with write-first bypass,
// opcode decode, load-use hazard detection and the ID/EX pipeline register.
module inst_decode (
  input logic          clk,
  input logic          rst_n,
  inst_decode_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [9:0]  npc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } id_ex_t;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  logic [31:0] rf [32];
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic        use_rs;
  logic        use_rt;
  logic        hazard;
  id_ex_t      id_ex_d;
  id_ex_t      id_ex_q;

  assign op    = bus.if_id_instr[31:26];
  assign rs    = bus.if_id_instr[25:21];
  assign rt    = bus.if_id_instr[20:16];
  assign rd    = bus.if_id_instr[15:11];
  assign imm16 = bus.if_id_instr[15:0];

  // r0 is never written, so its storage stays at the reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // The r0 test comes first so a write-back aimed at r0 is never bypassed.
  always_comb begin
    rs_data = rf[rs];
    if (rs == 5'd0) begin
      rs_data = '0;
    end else if (bus.wb_we && (bus.wb_addr == rs)) begin
      rs_data = bus.wb_data;
    end
  end

  always_comb begin
    rt_data = rf[rt];
    if (rt == 5'd0) begin
      rt_data = '0;
    end else if (bus.wb_we && (bus.wb_addr == rt)) begin
      rt_data = bus.wb_data;
    end
  end

  // Instructions that do not write a register carry dest=0 so they never match.
  always_comb begin
    id_ex_d         = '0;
    id_ex_d.rs_data = rs_data;
    id_ex_d.rt_data = rt_data;
    id_ex_d.imm     = {{16{imm16[15]}}, imm16};
    id_ex_d.npc     = bus.if_id_NPC;
    id_ex_d.rs      = rs;
    id_ex_d.rt      = rt;
    use_rs          = 1'b0;
    use_rt          = 1'b0;
    case (op)
      OP_RTYPE: begin
        id_ex_d.alu_op    = bus.if_id_instr[3:0];
        id_ex_d.dest      = rd;
        id_ex_d.reg_write = 1'b1;
        use_rs            = 1'b1;
        use_rt            = 1'b1;
      end
      OP_ADDI: begin
        id_ex_d.alu_op    = ALU_ADD;
        id_ex_d.dest      = rt;
        id_ex_d.reg_write = 1'b1;
        use_rs            = 1'b1;
      end
      OP_LW: begin
        id_ex_d.alu_op     = ALU_ADD;
        id_ex_d.dest       = rt;
        id_ex_d.reg_write  = 1'b1;
        id_ex_d.mem_read   = 1'b1;
        id_ex_d.mem_to_reg = 1'b1;
        use_rs             = 1'b1;
      end
      OP_SW: begin
        id_ex_d.alu_op    = ALU_ADD;
        id_ex_d.mem_write = 1'b1;
        use_rs            = 1'b1;
        use_rt            = 1'b1;
      end
      OP_BEQ: begin
        id_ex_d.alu_op = ALU_SUB;
        id_ex_d.branch = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      OP_J: begin
        id_ex_d.imm  = {22'b0, bus.if_id_instr[9:0]};
        id_ex_d.jump = 1'b1;
      end
      default: begin
        id_ex_d.alu_op = ALU_ADD;
      end
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    if (id_ex_q.mem_read && (id_ex_q.dest != 5'd0)) begin
      hazard = (use_rs && (id_ex_q.dest == rs)) ||
               (use_rt && (id_ex_q.dest == rt));
    end
  end

  // A flush overrides the stall: the stalled instruction is on the wrong path.
  assign bus.id_stall = hazard & ~bus.PCSrc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else if (bus.PCSrc || hazard) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.id_ex_rs_data    = id_ex_q.rs_data;
  assign bus.id_ex_rt_data    = id_ex_q.rt_data;
  assign bus.id_ex_imm        = id_ex_q.imm;
  assign bus.id_ex_NPC        = id_ex_q.npc;
  assign bus.id_ex_rs         = id_ex_q.rs;
  assign bus.id_ex_rt         = id_ex_q.rt;
  assign bus.id_ex_dest       = id_ex_q.dest;
  assign bus.id_ex_alu_op     = id_ex_q.alu_op;
  assign bus.id_ex_reg_write  = id_ex_q.reg_write;
  assign bus.id_ex_mem_read   = id_ex_q.mem_read;
  assign bus.id_ex_mem_write  = id_ex_q.mem_write;
  assign bus.id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign bus.id_ex_branch     = id_ex_q.branch;
  assign bus.id_ex_jump       = id_ex_q.jump;

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed instruction sequence with expected ID/EX
// contents queued at drive time and compared after the capturing edge.
module tb_inst_decode;

  logic clk;
  logic rst_n;
  inst_decode_if bus ();

  inst_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [9:0]  npc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu;
    logic [5:0]  flags;
  } exp_t;

  // flags: {reg_write, mem_read, mem_write, mem_to_reg, branch, jump}
  localparam logic [5:0] F_RW  = 6'b100000;
  localparam logic [5:0] F_MR  = 6'b010000;
  localparam logic [5:0] F_MW  = 6'b001000;
  localparam logic [5:0] F_MTR = 6'b000100;
  localparam logic [5:0] F_BR  = 6'b000010;
  localparam logic [5:0] F_J   = 6'b000001;
  localparam logic [5:0] F_LW  = F_RW | F_MR | F_MTR;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rs_data, input logic [31:0] rt_data,
                              input logic [31:0] imm, input logic [9:0] npc,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dest, input logic [3:0] alu,
                              input logic [5:0] flags);
    exp_t e;
    e.rs_data = rs_data; e.rt_data = rt_data; e.imm = imm; e.npc = npc;
    e.rs = rs; e.rt = rt; e.dest = dest; e.alu = alu; e.flags = flags;
    return e;
  endfunction

  task automatic compare_idex(input string tag, input exp_t e);
    check({tag, "/rs_data"}, bus.id_ex_rs_data, e.rs_data);
    check({tag, "/rt_data"}, bus.id_ex_rt_data, e.rt_data);
    check({tag, "/imm"},     bus.id_ex_imm,     e.imm);
    check({tag, "/npc"},     {22'b0, bus.id_ex_NPC},  {22'b0, e.npc});
    check({tag, "/rs"},      {27'b0, bus.id_ex_rs},   {27'b0, e.rs});
    check({tag, "/rt"},      {27'b0, bus.id_ex_rt},   {27'b0, e.rt});
    check({tag, "/dest"},    {27'b0, bus.id_ex_dest}, {27'b0, e.dest});
    check({tag, "/alu_op"},  {28'b0, bus.id_ex_alu_op}, {28'b0, e.alu});
    check({tag, "/flags"},
          {26'b0, bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
           bus.id_ex_mem_to_reg, bus.id_ex_branch, bus.id_ex_jump},
          {26'b0, e.flags});
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [9:0] npc,
                      input logic pcsrc, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic exp_stall, input exp_t e);
    exp_t got;
    @(negedge clk);
    bus.if_id_instr = instr;
    bus.if_id_NPC   = npc;
    bus.PCSrc       = pcsrc;
    bus.wb_we       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    #1;
    check({tag, "/stall"}, {31'b0, bus.id_stall}, {31'b0, exp_stall});
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      compare_idex(tag, got);
    end
  endtask

  localparam logic [31:0] NOP     = 32'hFC00_0000;
  localparam logic [31:0] ADD_R5  = 32'h00A0_1820; // add r3,r5,r0
  localparam logic [31:0] ADDI_M1 = 32'h0405_FFFF; // addi r5,r0,-1
  localparam logic [31:0] ADD_324 = 32'h0044_1800; // add r3,r2,r4
  localparam logic [31:0] LW_21   = 32'h0822_0004; // lw r2,4(r1)
  localparam logic [31:0] ADD_R0  = 32'h0000_1820; // add r3,r0,r0

  exp_t zero_e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_e          = '0;
    rst_n           = 1'b0;
    bus.if_id_instr = NOP;
    bus.if_id_NPC   = '0;
    bus.PCSrc       = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    #2;
    compare_idex("reset", zero_e);
    check("reset/stall", {31'b0, bus.id_stall}, 32'd0);
    #1 rst_n = 1'b1;

    step("wr_r5",   NOP,     10'd0, 0, 1, 5'd5, 32'h0000_AAAA, 0, zero_e);
    step("rd_r5",   ADD_R5,  10'd1, 0, 0, 5'd0, 32'h0, 0,
         mk(32'hAAAA, 0, 32'h1820, 10'd1, 5'd5, 5'd0, 5'd3, 4'h0, F_RW));
    step("pre_rst", ADDI_M1, 10'd2, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 32'hAAAA, 32'hFFFF_FFFF, 10'd2, 5'd0, 5'd5, 5'd5, 4'h0, F_RW));

    // asynchronous reset pulse between edges
    rst_n = 1'b0;
    #1;
    compare_idex("mid_rst", zero_e);
    check("mid_rst/stall", {31'b0, bus.id_stall}, 32'd0);
    #1 rst_n = 1'b1;

    step("rd_r5_rst", ADD_R5, 10'd1, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h1820, 10'd1, 5'd5, 5'd0, 5'd3, 4'h0, F_RW));
    step("addi",    ADDI_M1, 10'd7, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'hFFFF_FFFF, 10'd7, 5'd0, 5'd5, 5'd5, 4'h0, F_RW));
    step("bypass",  ADD_324, 10'd8, 0, 1, 5'd2, 32'h1234, 0,
         mk(32'h1234, 0, 32'h1800, 10'd8, 5'd2, 5'd4, 5'd3, 4'h0, F_RW));
    step("lw",      LW_21,   10'd9, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 32'h1234, 32'h4, 10'd9, 5'd1, 5'd2, 5'd2, 4'h0, F_LW));
    step("lu_stall", ADD_324, 10'd10, 0, 0, 5'd0, 32'h0, 1, zero_e);
    step("lu_issue", ADD_324, 10'd10, 0, 0, 5'd0, 32'h0, 0,
         mk(32'h1234, 0, 32'h1800, 10'd10, 5'd2, 5'd4, 5'd3, 4'h0, F_RW));
    step("lw2",     LW_21,   10'd11, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 32'h1234, 32'h4, 10'd11, 5'd1, 5'd2, 5'd2, 4'h0, F_LW));
    step("flush_haz", ADD_324, 10'd12, 1, 0, 5'd0, 32'h0, 0, zero_e);
    step("flush",   ADD_324, 10'd13, 1, 0, 5'd0, 32'h0, 0, zero_e);
    step("r0_wr",   ADD_R0,  10'd14, 0, 1, 5'd0, 32'h0000_FFFF, 0,
         mk(0, 0, 32'h1820, 10'd14, 5'd0, 5'd0, 5'd3, 4'h0, F_RW));
    step("lw_r0",   32'h0820_0004, 10'd15, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h4, 10'd15, 5'd1, 5'd0, 5'd0, 4'h0, F_LW));
    step("r0_nostall", ADD_R0, 10'd16, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h1820, 10'd16, 5'd0, 5'd0, 5'd3, 4'h0, F_RW));
    step("lw_r5",   32'h0805_0000, 10'd17, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h0, 10'd17, 5'd0, 5'd5, 5'd5, 4'h0, F_LW));
    step("addi_rt_unused", 32'h0405_0001, 10'd18, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h1, 10'd18, 5'd0, 5'd5, 5'd5, 4'h0, F_RW));
    step("lw_r4",   32'h0804_0000, 10'd19, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h0, 10'd19, 5'd0, 5'd4, 5'd4, 4'h0, F_LW));
    step("sw_rt_stall", 32'h0C04_0000, 10'd20, 0, 0, 5'd0, 32'h0, 1, zero_e);
    step("sw",      32'h0C04_0000, 10'd20, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h0, 10'd20, 5'd0, 5'd4, 5'd0, 4'h0, F_MW));
    step("beq",     32'h1043_0005, 10'd21, 0, 0, 5'd0, 32'h0, 0,
         mk(32'h1234, 0, 32'h5, 10'd21, 5'd2, 5'd3, 5'd0, 4'h1, F_BR));
    step("j",       32'h1400_8155, 10'd22, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h155, 10'd22, 5'd0, 5'd0, 5'd0, 4'h0, F_J));
    step("slt",     32'h0045_382A, 10'd23, 0, 0, 5'd0, 32'h0, 0,
         mk(32'h1234, 0, 32'h382A, 10'd23, 5'd2, 5'd5, 5'd7, 4'hA, F_RW));
    step("bad_op",  32'h1800_0000, 10'd24, 0, 0, 5'd0, 32'h0, 0,
         mk(0, 0, 32'h0, 10'd24, 5'd0, 5'd0, 5'd0, 4'h0, 6'b0));
    step("wr_r6a",  NOP,     10'd0, 0, 1, 5'd6, 32'h1, 0, zero_e);
    step("wr_r6b",  NOP,     10'd0, 0, 1, 5'd6, 32'h2, 0, zero_e);
    step("rd_r6",   32'h00C0_0020, 10'd25, 0, 0, 5'd0, 32'h0, 0,
         mk(32'h2, 0, 32'h20, 10'd25, 5'd6, 5'd0, 5'd0, 4'h0, F_RW));

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
